digit_serial_adder: RTL and testbench
=====================================

# digit_serial_adder

Parametrised digit-serial adder/subtractor built from a chain of DIGIT full-adder cells and a registered carry. It processes WIDTH-bit operands DIGIT bits per clock, LSB digit first. It trades latency for area in datapaths where a full WIDTH-bit ripple or lookahead adder is too large. Operands enter and results leave through valid/ready handshakes, so the block drops between any producer and consumer in the standard-cell flow.

## Interface
- WIDTH, 16, operand and result width in bits; must be a multiple of DIGIT, otherwise elaboration fails.
- DIGIT, 4, bits processed per cycle (1..WIDTH); NSTEP = WIDTH/DIGIT.
- CLK  in  1  clock; all state changes on the rising edge.
- R  in  1  reset, asynchronous, active-low.
- IN_VALID  in  1  operand set valid.
- IN_READY  out  1  block can accept operands (high only in IDLE).
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- CIN  in  1  carry-in (SUB=0) or borrow-in (SUB=1).
- SUB  in  1  0: S = A + B + CIN; 1: S = A − B − CIN.
- OUT_VALID  out  1  result valid.
- OUT_READY  in  1  consumer accepts result.
- S  out  WIDTH  result, modulo 2^WIDTH.
- COUT  out  1  carry-out; for SUB=1 this is NOT borrow (1 = no borrow).
- OVF  out  1  two's-complement overflow of the operation.
- BUSY  out  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: IN_READY=1. When IN_VALID & IN_READY at an edge, the block captures:
  - areg=A;
  - breg=B, or ~B when SUB=1;
  - carry=CIN^SUB;
  - step counter=0;
  - then moves to RUN.
- RUN, on each edge:
  - The low DIGIT bits of areg and breg plus carry go through DIGIT chained full adders.
  - The DIGIT sum bits shift into sreg from the MSB end.
  - areg and breg shift right by DIGIT.
  - carry takes the chain's carry-out.
  - The counter increments.
- On the edge with counter = NSTEP−1:
  - COUT takes the final carry.
  - OVF = carry into bit WIDTH−1 XOR carry out of bit WIDTH−1.
  - The block moves to DONE.
- DONE: OUT_VALID=1. S, COUT and OVF are held stable. IN_READY=0 and IN_VALID is ignored. On OUT_VALID & OUT_READY the block returns to IDLE.
- S, COUT and OVF:
  - are meaningful only while OUT_VALID=1;
  - keep the last result in IDLE;
  - S may show partial digits during RUN.
- Arithmetic is exact modulo 2^WIDTH and equals the single-cycle result A + (SUB ? ~B : B) + (CIN^SUB).
- DIGIT=WIDTH is legal: NSTEP=1, the block is a registered full-width ripple adder.
- DIGIT=1 is legal: bit-serial, NSTEP=WIDTH.
- Reset mid-operation: asserting R in any state aborts immediately. The block returns to IDLE with all registers cleared, and the aborted operation never produces OUT_VALID.

## Timing
- Reset values:
  - IN_READY=1, OUT_VALID=0, S=0, COUT=0, OVF=0, BUSY=0;
  - state IDLE, carry=0, counter=0.
- Counter width is max(1, clog2(NSTEP)). The counter never wraps: it is cleared on acceptance and used only in RUN.
- Latency: input handshake at edge 0; digits are computed at edges 1..NSTEP; OUT_VALID is high from just after edge NSTEP.
- Output handshake at edge k makes IN_READY high after edge k. The earliest next acceptance is edge k+1.
- Maximum throughput is one operation per NSTEP+2 cycles (OUT_READY and IN_VALID held high).
- IN_READY, OUT_VALID and BUSY are decoded from state only, with no combinational path from IN_VALID or OUT_READY.
- Combinational depth per cycle is DIGIT full-adder carry stages.

## Test plan
WIDTH=16, DIGIT=4 unless stated.
- Reset: hold R=0 with random inputs → IN_READY=1, OUT_VALID=0, S=0x0000, COUT=0, OVF=0, BUSY=0. Then release R.
- Basic add:
  - A=0x1234, B=0x4321, CIN=0, SUB=0 → OUT_VALID exactly 4 edges after acceptance, S=0x5555, COUT=0, OVF=0.
- Carry and overflow:
  - 0xFFFF+0x0001 → S=0x0000, COUT=1, OVF=0;
  - 0x7FFF+0x0001 → S=0x8000, COUT=0, OVF=1;
  - 0x0000+0x0000 with CIN=1 → S=0x0001.
- Subtract:
  - 0x0005−0x0007, CIN=0 → S=0xFFFE, COUT=0, OVF=0;
  - 0x8000−0x0001 → S=0x7FFF, COUT=1, OVF=1;
  - 0x0010−0x0010 with CIN=1 → S=0xFFFF, COUT=0.
- Backpressure: OUT_READY=0 for 10 cycles with IN_VALID=1 and changing A/B → OUT_VALID stays high, S/COUT/OVF stable, IN_READY=0, no new capture. Then OUT_READY=1 → next operation accepted one edge later, back-to-back period 6 cycles.
- Abort and configs:
  - assert R after 2 RUN edges → all outputs at reset values and no OUT_VALID;
  - rerun scenario 2 with DIGIT=16 (latency 1) and DIGIT=1 (latency 16) → same S, COUT and OVF values.

Source files
------------

// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: DIGIT full-adder cells plus a registered carry,
// consuming WIDTH-bit operands LSB digit first with valid/ready on both sides.
module digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] s_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             busy_o
);

  localparam int NSTEP = WIDTH / DIGIT;
  localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("digit_serial_adder: WIDTH must be a multiple of DIGIT and DIGIT in 1..WIDTH");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT:0]   c;
  logic [DIGIT-1:0] sum;
  logic [WIDTH-1:0] s_shift;
  logic             last_step;

  always_comb begin
    c   = '0;
    sum = '0;
    c[0] = carry_q;
    for (int i = 0; i < DIGIT; i++) begin
      sum[i]   = a_q[i] ^ b_q[i] ^ c[i];
      c[i+1]   = (a_q[i] & b_q[i]) | (c[i] & (a_q[i] ^ b_q[i]));
    end
  end

  // New digits enter at the MSB so the LSB digit ends up at bit 0 after NSTEP shifts.
  if (DIGIT == WIDTH) begin : g_full
    assign s_shift = sum;
  end else begin : g_part
    assign s_shift = {sum, s_q[WIDTH-1:DIGIT]};
  end

  assign last_step = (cnt_q == CW'(NSTEP - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          a_d     = a_i;
          b_d     = sub_i ? ~b_i : b_i;
          carry_d = cin_i ^ sub_i;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        s_d     = s_shift;
        carry_d = c[DIGIT];
        if (last_step) begin
          cout_d  = c[DIGIT];
          ovf_d   = c[DIGIT] ^ c[DIGIT-1];
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);
  assign s_o         = s_q;
  assign cout_o      = cout_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed bench for digit_serial_adder: DIGIT=4, 16 and 1 instances share stimulus.
module tb_digit_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;

  logic        rdy [3];
  logic        ovl [3];
  logic        co  [3];
  logic        of  [3];
  logic        bz  [3];
  logic [15:0] s   [3];

  int total = 0;
  int bad   = 0;
  int lat_exp [3] = '{4, 1, 16};

  always #5 clk = ~clk;

  digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u_d4 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy[0]),
    .a_i(a), .b_i(b), .cin_i(cin), .sub_i(sub), .out_valid_o(ovl[0]),
    .out_ready_i(out_ready), .s_o(s[0]), .cout_o(co[0]), .ovf_o(of[0]), .busy_o(bz[0]));

  digit_serial_adder #(.WIDTH(16), .DIGIT(16)) u_d16 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy[1]),
    .a_i(a), .b_i(b), .cin_i(cin), .sub_i(sub), .out_valid_o(ovl[1]),
    .out_ready_i(out_ready), .s_o(s[1]), .cout_o(co[1]), .ovf_o(of[1]), .busy_o(bz[1]));

  digit_serial_adder #(.WIDTH(16), .DIGIT(1)) u_d1 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy[2]),
    .a_i(a), .b_i(b), .cin_i(cin), .sub_i(sub), .out_valid_o(ovl[2]),
    .out_ready_i(out_ready), .s_o(s[2]), .cout_o(co[2]), .ovf_o(of[2]), .busy_o(bz[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic wait_all_idle(input string tag);
    int n = 0;
    while (!(rdy[0] && rdy[1] && rdy[2]) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_idle"}, {31'd0, rdy[0] & rdy[1] & rdy[2]}, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic tc, input logic ts,
                        input logic [15:0] es, input logic ec, input logic eo);
    int          lat [3];
    logic [15:0] rs  [3];
    logic        rc  [3];
    logic        ro  [3];
    wait_all_idle(tag);
    a = ta; b = tb_v; cin = tc; sub = ts; out_ready = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    for (int d = 0; d < 3; d++) begin
      lat[d] = -1; rs[d] = 'x; rc[d] = 'x; ro[d] = 'x;
    end
    @(negedge clk);
    for (int cyc = 1; cyc <= 40 && (lat[0] < 0 || lat[1] < 0 || lat[2] < 0); cyc++) begin
      @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (lat[d] < 0 && ovl[d]) begin
          lat[d] = cyc; rs[d] = s[d]; rc[d] = co[d]; ro[d] = of[d];
        end
      end
    end
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s_lat%0d", tag, d), 32'(lat[d]), 32'(lat_exp[d]));
      chk($sformatf("%s_s%0d", tag, d), {16'd0, rs[d]}, {16'd0, es});
      chk($sformatf("%s_cout%0d", tag, d), {31'd0, rc[d]}, {31'd0, ec});
      chk($sformatf("%s_ovf%0d", tag, d), {31'd0, ro[d]}, {31'd0, eo});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int  n;
    bit  r;
    bit  seen;

    // reset held with random activity on the inputs
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'($urandom); out_ready = 1'($urandom);
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      @(negedge clk);
    end
    chk("rst_in_ready", {31'd0, rdy[0]}, 32'd1);
    chk("rst_out_valid", {31'd0, ovl[0]}, 32'd0);
    chk("rst_s", {16'd0, s[0]}, 32'h0);
    chk("rst_cout", {31'd0, co[0]}, 32'd0);
    chk("rst_ovf", {31'd0, of[0]}, 32'd0);
    chk("rst_busy", {31'd0, bz[0]}, 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_op("add",     16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op("addc",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("addovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("addcin",  16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0);
    run_op("subneg",  16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("subovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_op("subbin",  16'h0010, 16'h0010, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0);

    // backpressure: result must hold while new operands are offered
    wait_all_idle("bp");
    out_ready = 1'b0;
    a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (!ovl[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid", {31'd0, ovl[0]}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("bp_hold_valid%0d", i), {31'd0, ovl[0]}, 32'd1);
      chk($sformatf("bp_hold_s%0d", i), {16'd0, s[0]}, 32'h3333);
      chk($sformatf("bp_hold_cout%0d", i), {31'd0, co[0]}, 32'd0);
      chk($sformatf("bp_hold_ready%0d", i), {31'd0, rdy[0]}, 32'd0);
    end
    a = 16'h0101; b = 16'h0202; cin = 1'b0; sub = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_ready", {31'd0, rdy[0]}, 32'd1);
    @(posedge clk); #1;
    chk("bp_accept_busy", {31'd0, bz[0]}, 32'd1);
    chk("bp_accept_ready", {31'd0, rdy[0]}, 32'd0);
    n = 0;
    r = 1'b0;
    while (!r && n < 20) begin
      @(negedge clk);
      r = rdy[0];
      @(posedge clk);
      n++;
    end
    chk("b2b_period", 32'(n), 32'd6);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("b2b_valid", {31'd0, ovl[0]}, 32'd1);
    chk("b2b_s", {16'd0, s[0]}, 32'h0303);
    #1;
    in_valid = 1'b0;

    // abort after two RUN edges
    wait_all_idle("abort");
    a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", {31'd0, rdy[0]}, 32'd1);
    chk("abort_out_valid", {31'd0, ovl[0]}, 32'd0);
    chk("abort_s", {16'd0, s[0]}, 32'h0);
    chk("abort_cout", {31'd0, co[0]}, 32'd0);
    chk("abort_ovf", {31'd0, of[0]}, 32'd0);
    chk("abort_busy", {31'd0, bz[0]}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ovl[0] || ovl[1] || ovl[2]) seen = 1'b1;
    end
    chk("abort_no_valid", {31'd0, seen}, 32'd0);

    run_op("post_abort", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
